// File: rtl/rejunity_1_58bit.sv
`default_nettype none
// ============================================================================
// Module   : rejunity_1_58bit
// Brief    : Ternary-weight x int8 activation engine, four 16-sample dot
//            products per block, results streamed out one byte per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rejunity_1_58bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned C_LANES = 4;
  localparam logic [3:0]  C_LAST  = 4'd15;

  logic [3:0]         r_cnt;
  logic signed [15:0] r_acc [C_LANES];
  logic signed [15:0] r_res [C_LANES];
  logic signed [15:0] w_prod [C_LANES];
  logic signed [15:0] w_x16;
  logic [7:0]         w_byte;
  logic               w_unused_ena;

  assign w_unused_ena = ena;
  assign w_x16        = {{8{uio_in[7]}}, uio_in};

  // Negation happens after sign extension so that x = -128 yields +128.
  generate
    for (genvar i = 0; i < C_LANES; i++) begin : g_lane
      assign w_prod[i] = (ui_in[2*i +: 2] == 2'b01) ? w_x16 :
                         (ui_in[2*i +: 2] == 2'b11) ? -w_x16 : 16'sd0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt <= 4'd0;
      for (int i = 0; i < C_LANES; i++) begin
        r_acc[i] <= 16'sd0;
        r_res[i] <= 16'sd0;
      end
    end else if (r_cnt == C_LAST) begin
      r_cnt <= 4'd0;
      for (int i = 0; i < C_LANES; i++) begin
        r_res[i] <= r_acc[i] + w_prod[i];
        r_acc[i] <= 16'sd0;
      end
    end else begin
      r_cnt <= r_cnt + 4'd1;
      for (int i = 0; i < C_LANES; i++) begin
        r_acc[i] <= r_acc[i] + w_prod[i];
      end
    end
  end

  // First half of each block streams res[cnt/2], low byte first.
  always_comb begin
    w_byte = 8'h00;
    if (!r_cnt[3]) begin
      w_byte = r_cnt[0] ? r_res[r_cnt[2:1]][15:8] : r_res[r_cnt[2:1]][7:0];
    end
  end

  assign uo_out  = w_byte;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_rejunity_1_58bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rejunity_1_58bit
// Brief    : Directed self-checking bench for rejunity_1_58bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rejunity_1_58bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int num_vec = 0;
  int num_err = 0;

  rejunity_1_58bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    num_vec++;
    assert (obs === exp) else begin
      num_err++;
      $error("FAIL %s k=%0d: observed %02h expected %02h", tag, k, obs, exp);
    end
  endtask

  // Feed n samples; before each edge, check the byte streamed from the
  // previous block's results (packed {res3,res2,res1,res0}).
  task automatic run(input string tag, input logic [7:0] w, input logic [7:0] x,
                     input int n, input logic [63:0] prev);
    for (int k = 0; k < n; k++) begin
      ui_in  = w;
      uio_in = x;
      ena    = 1'($urandom_range(0, 1));
      check(tag, k, uo_out, (k < 8) ? prev[8*k +: 8] : 8'h00);
      check({tag, "_oe"}, k, uio_oe | uio_out, 8'h00);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_uo", 0, uo_out, 8'h00);
    check("rst_oe", 0, uio_oe, 8'h00);
    check("rst_uio", 0, uio_out, 8'h00);
    rst_n = 1'b0;

    run("zero",   8'h00, 8'd0,   16, 64'h0);
    run("allp1",  8'h55, 8'd1,   16, 64'h0);
    run("neg127", 8'hFF, 8'd127, 16, {4{16'h0010}});
    run("neg128", 8'hFF, 8'h80,  16, {4{16'hF810}});
    run("mixed",  8'hB4, 8'd5,   16, {4{16'h0800}});
    run("blkA",   8'h55, 8'd2,   16, {16'h0000, 16'hFFB0, 16'h0050, 16'h0000});
    run("blkB",   8'h55, 8'd3,   16, {4{16'h0020}});
    run("partial", 8'h55, 8'd9,   7, {4{16'h0030}});

    rst_n = 1'b1;
    ena   = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_uo", 0, uo_out, 8'h00);
    rst_n = 1'b0;

    run("after_rst", 8'h55, 8'd1, 16, 64'h0);
    run("final",     8'h00, 8'd0, 16, {4{16'h0010}});

    $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
    $finish;
  end

endmodule
`default_nettype wire
